pixel_writer: RTL and testbench

- Consumer end of the line-drawer pixel interface.
- Accepts single-cycle plot strobes carrying x, y and colour, and queues them in a small FIFO.
- Converts each coordinate to a linear frame-buffer address and issues writes to the video memory port using a valid/ready handshake.
- Also performs a full-screen clear on request. Sits between the line drawer and the VGA frame-buffer RAM.

---
 rtl/pixel_writer_pkg.sv | 24 ++
 rtl/pixel_writer_if.sv | 28 ++
 rtl/pixel_writer_fifo.sv | 58 +++++
 rtl/pixel_writer.sv | 204 ++++++++++++++++++++
 tb/tb_pixel_writer.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pixel_writer_pkg.sv
// Shared constants and types for the pixel writer: screen geometry, entry layout
// and FSM state encoding.
package pixel_writer_pkg;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int COLOUR_W = 3;
  localparam int ADDR_W   = 17;
  localparam int X_W      = 9;
  localparam int Y_W      = 8;
  localparam int PIX_W    = X_W + Y_W + COLOUR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    CLEAR = 2'd2
  } state_t;

  // Width of one queued {x, y, colour} entry for a given colour depth.
  function automatic int pix_w(input int cw);
    return X_W + Y_W + cw;
  endfunction

endpackage

// File: rtl/pixel_writer_if.sv
// Frame-buffer write port: valid/ready handshake carrying address and colour.
interface pixel_writer_if
  import pixel_writer_pkg::*;
#(
  parameter int ADDR_W   = pixel_writer_pkg::ADDR_W,
  parameter int COLOUR_W = pixel_writer_pkg::COLOUR_W
);

  logic                mem_wren;
  logic [ADDR_W-1:0]   mem_addr;
  logic [COLOUR_W-1:0] mem_data;
  logic                mem_ready;

  modport master (
    output mem_wren,
    output mem_addr,
    output mem_data,
    input  mem_ready
  );

  modport slave (
    input  mem_wren,
    input  mem_addr,
    input  mem_data,
    output mem_ready
  );

endinterface

// File: rtl/pixel_writer_fifo.sv
// Small synchronous FIFO for queued pixels; a pop and a push may share a cycle
// even when full, since the popped slot is the one being overwritten.
module pixel_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == DEPTH_C);
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign dout    = mem[rd_ptr_reg];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/pixel_writer.sv
// Queues plotted pixels, converts them to linear frame-buffer addresses and
// writes them out over a valid/ready port; also sweeps a full-screen clear.
module pixel_writer
  import pixel_writer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int SCREEN_W   = pixel_writer_pkg::SCREEN_W,
  parameter int SCREEN_H   = pixel_writer_pkg::SCREEN_H,
  parameter int COLOUR_W   = pixel_writer_pkg::COLOUR_W,
  parameter int ADDR_W     = pixel_writer_pkg::ADDR_W
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                plot,
  input  logic [8:0]          x,
  input  logic [7:0]          y,
  input  logic [COLOUR_W-1:0] colour,
  input  logic                clear_go,
  input  logic [COLOUR_W-1:0] clear_colour,
  pixel_writer_if.master      vmem,
  output logic                full,
  output logic                busy,
  output logic                clear_done,
  output logic                overflow,
  output logic                dropped
);

  localparam int ENTRY_W = pix_w(COLOUR_W);
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SCREEN_W * SCREEN_H - 1);
  localparam logic [9:0] SW_C = 10'(SCREEN_W);
  localparam logic [8:0] SH_C = 9'(SCREEN_H);

  state_t state_reg, state_next;

  logic                wren_reg, wren_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [COLOUR_W-1:0] data_reg, data_next;
  logic                clear_done_reg, clear_done_next;
  logic                clear_pending_reg;
  logic [COLOUR_W-1:0] clear_colour_reg;
  logic                overflow_reg;
  logic                dropped_reg;
  logic                clear_end;

  logic                on_screen;
  logic                fifo_push;
  logic                fifo_pop;
  logic [ENTRY_W-1:0]  fifo_dout;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CNT_W-1:0]    fifo_count;
  logic [8:0]          head_x;
  logic [7:0]          head_y;
  logic [COLOUR_W-1:0] head_c;
  logic [ADDR_W-1:0]   head_addr;
  logic                accept;

  assign on_screen = ({1'b0, x} < SW_C) && ({1'b0, y} < SH_C);
  assign fifo_push = plot && on_screen && (!fifo_full || fifo_pop);
  assign accept    = wren_reg && vmem.mem_ready;

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (CLOCK_50),
    .srst  (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({x, y, colour}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign head_x = fifo_dout[ENTRY_W-1 -: 9];
  assign head_y = fifo_dout[COLOUR_W +: 8];
  assign head_c = fifo_dout[COLOUR_W-1:0];

  // 320 = 256 + 64, so the default geometry needs only two shifts and adds.
  if (SCREEN_W == 320) begin : g_addr_shift
    assign head_addr = (ADDR_W'(head_y) << 8) + (ADDR_W'(head_y) << 6) + ADDR_W'(head_x);
  end else begin : g_addr_mul
    assign head_addr = ADDR_W'(head_y) * ADDR_W'(SCREEN_W) + ADDR_W'(head_x);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (clear_pending_reg && fifo_empty) state_next = CLEAR;
        else if (!fifo_empty)                state_next = WRITE;
      end
      WRITE: begin
        if (accept && (fifo_empty || clear_pending_reg)) state_next = IDLE;
      end
      CLEAR: begin
        if (accept && addr_reg == LAST_ADDR) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    fifo_pop        = 1'b0;
    wren_next       = wren_reg;
    addr_next       = addr_reg;
    data_next       = data_reg;
    clear_done_next = 1'b0;
    clear_end       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (clear_pending_reg && fifo_empty) begin
          wren_next = 1'b1;
          addr_next = '0;
          data_next = clear_colour_reg;
        end else if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          wren_next = 1'b1;
          addr_next = head_addr;
          data_next = head_c;
        end
      end
      WRITE: begin
        if (accept) begin
          // Chain straight into the next pixel unless a clear must go first.
          if (!fifo_empty && !clear_pending_reg) begin
            fifo_pop  = 1'b1;
            addr_next = head_addr;
            data_next = head_c;
          end else begin
            wren_next = 1'b0;
          end
        end
      end
      CLEAR: begin
        if (accept) begin
          if (addr_reg == LAST_ADDR) begin
            wren_next       = 1'b0;
            clear_done_next = 1'b1;
            clear_end       = 1'b1;
          end else begin
            addr_next = addr_reg + 1'b1;
          end
        end
      end
      default: wren_next = 1'b0;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wren_reg       <= 1'b0;
      addr_reg       <= '0;
      data_reg       <= '0;
      clear_done_reg <= 1'b0;
    end else begin
      wren_reg       <= wren_next;
      addr_reg       <= addr_next;
      data_reg       <= data_next;
      clear_done_reg <= clear_done_next;
    end
  end

  // The pending flag stays set through the sweep, so repeat requests are ignored.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      clear_pending_reg <= 1'b0;
      clear_colour_reg  <= '0;
    end else if (clear_end) begin
      clear_pending_reg <= 1'b0;
    end else if (clear_go && !clear_pending_reg) begin
      clear_pending_reg <= 1'b1;
      clear_colour_reg  <= clear_colour;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      overflow_reg <= 1'b0;
      dropped_reg  <= 1'b0;
    end else begin
      if (plot && !on_screen)                          dropped_reg  <= 1'b1;
      if (plot && on_screen && fifo_full && !fifo_pop) overflow_reg <= 1'b1;
    end
  end

  assign vmem.mem_wren = wren_reg;
  assign vmem.mem_addr = addr_reg;
  assign vmem.mem_data = data_reg;
  assign full          = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign busy          = !fifo_empty || wren_reg || clear_pending_reg || (state_reg != IDLE);
  assign clear_done    = clear_done_reg;
  assign overflow      = overflow_reg;
  assign dropped       = dropped_reg;

endmodule

// File: tb/tb_pixel_writer.sv
// Scoreboard bench for pixel_writer: expected writes are queued as stimulus is
// driven and checked in order as the memory port accepts them.
module tb_pixel_writer;

  typedef struct {
    logic [16:0] addr;
    logic [2:0]  data;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       plot = 1'b0;
  logic [8:0] x = '0;
  logic [7:0] y = '0;
  logic [2:0] colour = '0;
  logic       clear_go = 1'b0;
  logic [2:0] clear_colour = '0;
  logic       full, busy, clear_done, overflow, dropped;

  int   errors = 0;
  int   checks = 0;
  int   wr_cnt = 0;
  int   done_cnt = 0;
  exp_t exp_q[$];

  pixel_writer_if #(.ADDR_W(17), .COLOUR_W(3)) vmem ();

  pixel_writer dut (
    .CLOCK_50     (clk),
    .reset        (reset),
    .plot         (plot),
    .x            (x),
    .y            (y),
    .colour       (colour),
    .clear_go     (clear_go),
    .clear_colour (clear_colour),
    .vmem         (vmem.master),
    .full         (full),
    .busy         (busy),
    .clear_done   (clear_done),
    .overflow     (overflow),
    .dropped      (dropped)
  );

  always #5 clk = ~clk;

  // Inputs change only just after a rising edge, so the falling edge sees what the next edge will.
  always @(negedge clk) begin
    if (!reset) begin
      if (clear_done) done_cnt++;
      if (vmem.mem_wren && vmem.mem_ready) begin
        wr_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write addr=%0d data=%0d (none expected)", vmem.mem_addr, vmem.mem_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (vmem.mem_addr !== e.addr || vmem.mem_data !== e.data) begin
            errors++;
            $display("FAIL write_order got addr=%0d data=%0d, want addr=%0d data=%0d",
                     vmem.mem_addr, vmem.mem_data, e.addr, e.data);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    plot = 1'b0;
    clear_go = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic do_plot(input int px, input int py, input int pc, input bit expect_write);
    exp_t e;
    plot = 1'b1;
    x = 9'(px);
    y = 8'(py);
    colour = 3'(pc);
    if (expect_write) begin
      e.addr = 17'(py * 320 + px);
      e.data = 3'(pc);
      exp_q.push_back(e);
    end
    tick();
    plot = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles, input string name);
    int n = 0;
    while (busy && n < max_cycles) begin
      tick();
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL %s_timeout busy=%0b after %0d cycles, want 0", name, busy, n);
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL %s_drained pending=%0d want 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    vmem.mem_ready = 1'b1;
    do_reset();
    checks++;
    if ({vmem.mem_wren, vmem.mem_addr, vmem.mem_data, clear_done, overflow, dropped, full, busy} !== '0) begin
      errors++;
      $display("FAIL reset_state wren=%0b addr=%0d data=%0d done=%0b ovf=%0b drop=%0b full=%0b busy=%0b want all 0",
               vmem.mem_wren, vmem.mem_addr, vmem.mem_data, clear_done, overflow, dropped, full, busy);
    end
  endtask

  task automatic test_single();
    int w0 = wr_cnt;
    do_reset();
    vmem.mem_ready = 1'b1;
    do_plot(5, 2, 5, 1'b1);
    checks++;
    if (vmem.mem_wren !== 1'b0) begin
      errors++;
      $display("FAIL single_n1 wren=%0b want 0", vmem.mem_wren);
    end
    tick();
    checks++;
    if (vmem.mem_wren !== 1'b1 || vmem.mem_addr !== 17'd645 || vmem.mem_data !== 3'd5) begin
      errors++;
      $display("FAIL single_n2 wren=%0b addr=%0d data=%0d want 1/645/5", vmem.mem_wren, vmem.mem_addr, vmem.mem_data);
    end
    tick();
    checks++;
    if (vmem.mem_wren !== 1'b0) begin
      errors++;
      $display("FAIL single_n3 wren=%0b want 0", vmem.mem_wren);
    end
    wait_idle(20, "single");
    checks++;
    if (wr_cnt - w0 !== 1) begin
      errors++;
      $display("FAIL single_count writes=%0d want 1", wr_cnt - w0);
    end
    check_drained("single");
  endtask

  task automatic test_backpressure();
    int w0;
    do_reset();
    vmem.mem_ready = 1'b0;
    w0 = wr_cnt;
    do_plot(319, 239, 7, 1'b1);
    tick();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (vmem.mem_wren !== 1'b1 || vmem.mem_addr !== 17'd76799 || vmem.mem_data !== 3'd7) begin
        errors++;
        $display("FAIL hold_%0d wren=%0b addr=%0d data=%0d want 1/76799/7", i, vmem.mem_wren, vmem.mem_addr, vmem.mem_data);
      end
      tick();
    end
    vmem.mem_ready = 1'b1;
    tick();
    checks++;
    if (vmem.mem_wren !== 1'b0 || wr_cnt - w0 !== 1) begin
      errors++;
      $display("FAIL bp_release wren=%0b writes=%0d want 0/1", vmem.mem_wren, wr_cnt - w0);
    end
    check_drained("backpressure");
  endtask

  task automatic test_overflow();
    int w0;
    do_reset();
    vmem.mem_ready = 1'b0;
    w0 = wr_cnt;
    for (int i = 0; i < 6; i++) begin
      do_plot(i * 3, i, i, i < 5);
    end
    checks++;
    if (overflow !== 1'b1 || full !== 1'b1) begin
      errors++;
      $display("FAIL ovf_flags overflow=%0b full=%0b want 1/1", overflow, full);
    end
    vmem.mem_ready = 1'b1;
    wait_idle(40, "overflow");
    checks++;
    if (wr_cnt - w0 !== 5 || full !== 1'b0) begin
      errors++;
      $display("FAIL ovf_count writes=%0d full=%0b want 5/0", wr_cnt - w0, full);
    end
    check_drained("overflow");
  endtask

  task automatic test_offscreen();
    int w0;
    do_reset();
    vmem.mem_ready = 1'b1;
    w0 = wr_cnt;
    do_plot(320, 0, 1, 1'b0);
    do_plot(0, 240, 2, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (wr_cnt - w0 !== 0 || dropped !== 1'b1 || overflow !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL offscreen writes=%0d dropped=%0b overflow=%0b busy=%0b want 0/1/0/0",
               wr_cnt - w0, dropped, overflow, busy);
    end
  endtask

  task automatic test_clear();
    exp_t e;
    int d0;
    int n = 0;
    do_reset();
    d0 = done_cnt;
    vmem.mem_ready = 1'b0;
    do_plot(7, 3, 4, 1'b1);
    do_plot(8, 3, 6, 1'b1);
    clear_go = 1'b1;
    clear_colour = 3'b010;
    for (int a = 0; a < 76800; a++) begin
      e.addr = 17'(a);
      e.data = 3'b010;
      exp_q.push_back(e);
    end
    tick();
    // A second request while one is pending must be ignored.
    clear_colour = 3'b101;
    tick();
    clear_go = 1'b0;
    vmem.mem_ready = 1'b1;
    while (!(vmem.mem_wren && vmem.mem_addr == 17'd100 && vmem.mem_data == 3'b010) && n < 2000) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL clear_start addr=%0d data=%0d want sweep at 100 with data 2", vmem.mem_addr, vmem.mem_data);
    end
    do_plot(10, 10, 1, 1'b1);
    wait_idle(80000, "clear");
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL clear_done_pulses got=%0d want 1", done_cnt - d0);
    end
    check_drained("clear");
  endtask

  task automatic test_reset_mid_clear();
    exp_t e;
    int d0;
    int w0;
    int n = 0;
    do_reset();
    vmem.mem_ready = 1'b1;
    d0 = done_cnt;
    clear_go = 1'b1;
    clear_colour = 3'd3;
    for (int a = 0; a < 1000; a++) begin
      e.addr = 17'(a);
      e.data = 3'd3;
      exp_q.push_back(e);
    end
    tick();
    clear_go = 1'b0;
    while (!(vmem.mem_wren && vmem.mem_addr == 17'd1000) && n < 1500) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 1500) begin
      errors++;
      $display("FAIL rmc_reach addr=%0d want 1000", vmem.mem_addr);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (vmem.mem_wren !== 1'b0) begin
      errors++;
      $display("FAIL rmc_wren wren=%0b want 0", vmem.mem_wren);
    end
    check_drained("rmc_sweep");
    exp_q.delete();
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (done_cnt - d0 !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rmc_quiet done_pulses=%0d busy=%0b want 0/0", done_cnt - d0, busy);
    end
    w0 = wr_cnt;
    do_plot(1, 1, 4, 1'b1);
    wait_idle(20, "rmc_plot");
    checks++;
    if (wr_cnt - w0 !== 1) begin
      errors++;
      $display("FAIL rmc_plot writes=%0d want 1", wr_cnt - w0);
    end
    check_drained("rmc_plot");
  endtask

  initial begin
    vmem.mem_ready = 1'b1;
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_offscreen();
    test_clear();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
